// File: rtl/encoder_ram_arbiter_pkg.sv
// Shared definitions for the encoder RAM arbiter: requester slot indices and
// the default number of requesters sharing the dictionary/code RAM.
package encoder_pkg;

   localparam int REQ_HOST    = 0;
   localparam int REQ_ENCODER = 1;
   localparam int REQ_GROUPER = 2;

   localparam int ENC_NUM_REQ = 3;

endpackage

// File: rtl/encoder_ram_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping at NUM_REQ. Returns a one-hot grant, its index and an any flag.
module rr_priority_picker #(
   parameter int NUM_REQ = 3,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   idx,
   output logic               any
);

   int               j;
   logic [IDX_W-1:0] jj;

   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      j   = 0;
      jj  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = int'(ptr) + k;
         if (j >= NUM_REQ) begin
            j = j - NUM_REQ;
         end
         jj = IDX_W'(j);
         if (!any && req[jj]) begin
            gnt[jj] = 1'b1;
            idx     = jj;
            any     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/encoder_ram_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between NUM_REQ
// requesters, with lock ownership for read-modify-write and tagged read returns.
module encoder_ram_arbiter
   import encoder_pkg::*;
#(
   parameter int NUM_REQ    = ENC_NUM_REQ,
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_REQ-1:0]              req,
   input  logic [NUM_REQ-1:0]              we,
   input  logic [NUM_REQ-1:0]              lock,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]   addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   wdata,
   output logic [NUM_REQ-1:0]              gnt,
   output logic [NUM_REQ-1:0]              rvalid,
   output logic [DATA_WIDTH-1:0]           rdata,
   output logic                            mem_en,
   output logic                            mem_we,
   output logic [ADDR_WIDTH-1:0]           mem_addr,
   output logic [DATA_WIDTH-1:0]           mem_wdata,
   input  logic [DATA_WIDTH-1:0]           mem_rdata
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [IDX_W-1:0]   owner_q, owner_d;
   logic               owner_vld_q, owner_vld_d;
   logic [NUM_REQ-1:0] rvalid_q, rvalid_d;

   logic [NUM_REQ-1:0] pick_gnt;
   logic [IDX_W-1:0]   pick_idx;
   logic               pick_any;
   logic [NUM_REQ-1:0] gnt_c;

   function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
      if (int'(i) == NUM_REQ - 1) begin
         return '0;
      end
      return i + IDX_W'(1);
   endfunction

   rr_priority_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_picker (
      .req (req),
      .ptr (ptr_q),
      .gnt (pick_gnt),
      .idx (pick_idx),
      .any (pick_any)
   );

   // While a lock is held only the owner competes; ptr stays frozen until release.
   always_comb begin
      gnt_c       = '0;
      ptr_d       = ptr_q;
      owner_d     = owner_q;
      owner_vld_d = owner_vld_q;
      if (!rst) begin
         if (owner_vld_q) begin
            if (req[owner_q]) begin
               gnt_c[owner_q] = 1'b1;
            end
            if (!lock[owner_q]) begin
               owner_vld_d = 1'b0;
               ptr_d       = next_idx(owner_q);
            end
         end else if (pick_any) begin
            gnt_c = pick_gnt;
            ptr_d = next_idx(pick_idx);
            if (lock[pick_idx]) begin
               owner_vld_d = 1'b1;
               owner_d     = pick_idx;
            end
         end
      end
   end

   always_comb begin
      mem_en    = |gnt_c;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt_c[i]) begin
            mem_we    = we[i];
            mem_addr  = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            mem_wdata = wdata[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
      rvalid_d = gnt_c & ~we;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q       <= '0;
         owner_q     <= '0;
         owner_vld_q <= 1'b0;
         rvalid_q    <= '0;
      end else begin
         ptr_q       <= ptr_d;
         owner_q     <= owner_d;
         owner_vld_q <= owner_vld_d;
         rvalid_q    <= rvalid_d;
      end
   end

   assign gnt    = gnt_c;
   assign rvalid = rvalid_q;
   assign rdata  = mem_rdata;

endmodule

// File: tb/tb_encoder_ram_arbiter.sv
// Bench for encoder_ram_arbiter: directed scenarios plus randomized traffic
// checked against a behavioural arbitration/RAM model.
module tb_encoder_ram_arbiter;

   localparam int N  = 3;
   localparam int AW = 4;
   localparam int DW = 8;

   logic            clk;
   logic            rst;
   logic [N-1:0]    req, we, lock;
   logic [N*AW-1:0] addr;
   logic [N*DW-1:0] wdata;
   logic [N-1:0]    gnt, rvalid;
   logic [DW-1:0]   rdata;
   logic            mem_en, mem_we;
   logic [AW-1:0]   mem_addr;
   logic [DW-1:0]   mem_wdata, mem_rdata;

   logic [DW-1:0]   ram [16];
   logic            pl_en;
   logic [AW-1:0]   pl_addr;
   logic [DW-1:0]   pl_data;

   int              errors, checks;
   logic [DW-1:0]   shadow [16];

   int              m_ptr, m_owner;
   logic [N-1:0]    exp_rv;
   logic [DW-1:0]   exp_rd;

   encoder_ram_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst(rst), .req(req), .we(we), .lock(lock), .addr(addr),
      .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (pl_en) ram[pl_addr] <= pl_data;
      else if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         else mem_rdata <= ram[mem_addr];
      end
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_req(input int i, input bit r, input bit w, input bit l,
                          input int a, input int d);
      req[i]           = r;
      we[i]            = w;
      lock[i]          = l;
      addr[i*AW +: AW] = AW'(a);
      wdata[i*DW +: DW] = DW'(d);
   endtask

   task automatic clear_all();
      req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
   endtask

   task automatic pulse_reset();
      clear_all();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   function automatic logic [N-1:0] oh(input int g);
      logic [N-1:0] v;
      v = '0;
      if (g >= 0) v[g] = 1'b1;
      return v;
   endfunction

   // Winner under the arbitration rules: owner only while locked, else round robin from ptr.
   function automatic int model_pick();
      if (m_owner >= 0) return req[m_owner] ? m_owner : -1;
      for (int k = 0; k < N; k++) begin
         if (req[(m_ptr + k) % N]) return (m_ptr + k) % N;
      end
      return -1;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      req = '1;
      #1;
      checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL reset_gnt: got %b want 000", gnt); end
      checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en: got %b want 0", mem_en); end
      checks++; if (rvalid !== 3'b000) begin errors++; $display("FAIL reset_rvalid: got %b want 000", rvalid); end
      clear_all();
      for (int a = 0; a < 16; a++) begin
         pl_en = 1'b1; pl_addr = AW'(a);
         pl_data = (a == 5) ? 8'h3C : DW'($urandom);
         shadow[a] = pl_data;
         tick();
      end
      pl_en = 1'b0;
      rst = 1'b0;
   endtask

   task automatic test_single_read();
      set_req(1, 1, 0, 0, 5, 0);
      #1;
      checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL single_gnt: got %b want 010", gnt); end
      checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 4'd5) begin
         errors++; $display("FAIL single_mem: en=%b we=%b addr=%0d want en=1 we=0 addr=5", mem_en, mem_we, mem_addr); end
      tick();
      clear_all();
      #1;
      checks++; if (rvalid !== 3'b010) begin errors++; $display("FAIL single_rvalid: got %b want 010", rvalid); end
      checks++; if (rdata !== 8'h3C) begin errors++; $display("FAIL single_rdata: got %h want 3c", rdata); end
      checks++; if (gnt !== 3'b000 || mem_en !== 1'b0 || mem_addr !== 4'd0) begin
         errors++; $display("FAIL single_idle: gnt=%b en=%b addr=%0d want 000/0/0", gnt, mem_en, mem_addr); end
      tick();
   endtask

   task automatic test_round_robin();
      pulse_reset();
      for (int i = 0; i < N; i++) set_req(i, 1, 0, 0, i, 0);
      for (int c = 0; c < 6; c++) begin
         #1;
         checks++; if (gnt !== oh(c % 3)) begin
            errors++; $display("FAIL rr_gnt c%0d: got %b want %b", c, gnt, oh(c % 3)); end
         if (c > 0) begin
            checks++; if (rvalid !== oh((c - 1) % 3) || rdata !== shadow[(c - 1) % 3]) begin
               errors++; $display("FAIL rr_read c%0d: rvalid=%b rdata=%h want %b %h", c, rvalid, rdata,
                                  oh((c - 1) % 3), shadow[(c - 1) % 3]); end
         end
         tick();
      end
      clear_all();
      tick();
   endtask

   task automatic test_lock();
      int la [3];
      bit ll [3];
      la = '{1, 2, 3};
      ll = '{1'b1, 1'b1, 1'b0};
      for (int c = 0; c < 3; c++) begin
         set_req(2, 1, 0, ll[c], la[c], 0);
         if (c > 0) begin
            set_req(0, 1, 0, 0, 0, 0);
            set_req(1, 1, 0, 0, 0, 0);
         end
         #1;
         checks++; if (gnt !== 3'b100 || mem_addr !== AW'(la[c])) begin
            errors++; $display("FAIL lock_owner c%0d: gnt=%b addr=%0d want 100 %0d", c, gnt, mem_addr, la[c]); end
         if (c > 0) begin
            checks++; if (rvalid !== 3'b100 || rdata !== shadow[la[c-1]]) begin
               errors++; $display("FAIL lock_read c%0d: rvalid=%b rdata=%h want 100 %h", c, rvalid, rdata, shadow[la[c-1]]); end
         end
         tick();
      end
      set_req(2, 0, 0, 0, 0, 0);
      #1;
      checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL lock_after: got %b want 001", gnt); end
      tick();
      set_req(0, 0, 0, 0, 0, 0);
      #1;
      checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL lock_next: got %b want 010", gnt); end
      tick();
      clear_all();
      tick();
   endtask

   task automatic test_lock_idle();
      logic [N-1:0] want [5];
      want = '{3'b010, 3'b000, 3'b000, 3'b000, 3'b001};
      for (int c = 0; c < 5; c++) begin
         set_req(1, c == 0, 0, c < 3, 0, 0);
         set_req(0, c > 0, 0, 0, 9, 0);
         #1;
         checks++; if (gnt !== want[c] || mem_en !== (|want[c])) begin
            errors++; $display("FAIL lock_idle c%0d: gnt=%b en=%b want %b", c, gnt, mem_en, want[c]); end
         tick();
      end
      clear_all();
      tick();
   endtask

   task automatic test_write_read();
      set_req(0, 1, 1, 0, 7, 8'hA5);
      #1;
      checks++; if (gnt !== 3'b001 || mem_we !== 1'b1 || mem_wdata !== 8'hA5 || mem_addr !== 4'd7) begin
         errors++; $display("FAIL wr_mem: gnt=%b we=%b wdata=%h addr=%0d want 001 1 a5 7", gnt, mem_we, mem_wdata, mem_addr); end
      shadow[7] = 8'hA5;
      tick();
      set_req(0, 1, 0, 0, 7, 0);
      #1;
      checks++; if (rvalid !== 3'b000) begin errors++; $display("FAIL wr_no_rvalid: got %b want 000", rvalid); end
      tick();
      clear_all();
      #1;
      checks++; if (rvalid !== 3'b001 || rdata !== 8'hA5) begin
         errors++; $display("FAIL wr_readback: rvalid=%b rdata=%h want 001 a5", rvalid, rdata); end
      tick();
   endtask

   task automatic test_reset_mid_lock();
      set_req(2, 1, 0, 1, 4, 0);
      #1;
      checks++; if (gnt !== 3'b100) begin errors++; $display("FAIL rml_gnt: got %b want 100", gnt); end
      tick();
      set_req(0, 1, 0, 0, 0, 0);
      set_req(1, 1, 0, 0, 0, 0);
      #1;
      checks++; if (rvalid !== 3'b100) begin errors++; $display("FAIL rml_pre: rvalid=%b want 100", rvalid); end
      rst = 1'b1;
      #1;
      checks++; if (rvalid !== 3'b000 || gnt !== 3'b000 || mem_en !== 1'b0) begin
         errors++; $display("FAIL rml_rst: rvalid=%b gnt=%b en=%b want 000 000 0", rvalid, gnt, mem_en); end
      tick();
      rst = 1'b0;
      set_req(2, 1, 0, 0, 4, 0);
      #1;
      checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL rml_after: got %b want 001", gnt); end
      tick();
      clear_all();
      tick();
   endtask

   task automatic test_random();
      bit pend [N];
      int g;
      int a;
      pulse_reset();
      m_ptr = 0; m_owner = -1; exp_rv = '0; exp_rd = '0;
      for (int i = 0; i < N; i++) pend[i] = 1'b0;
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && $urandom_range(0, 99) < 45) begin
               pend[i] = 1'b1;
               set_req(i, 1, $urandom_range(0, 1), $urandom_range(0, 3) == 0,
                       $urandom_range(0, 15), $urandom_range(0, 255));
            end else if (!pend[i]) begin
               req[i]  = 1'b0;
               lock[i] = $urandom_range(0, 1);
            end
         end
         #1;
         g = model_pick();
         checks++; if (gnt !== oh(g) || mem_en !== (g >= 0)) begin
            errors++; $display("FAIL rnd_gnt c%0d: gnt=%b en=%b want %b", c, gnt, mem_en, oh(g)); end
         if (g >= 0) begin
            checks++; if (mem_we !== we[g] || mem_addr !== addr[g*AW +: AW] ||
                          mem_wdata !== wdata[g*DW +: DW]) begin
               errors++; $display("FAIL rnd_mem c%0d: we=%b addr=%0d wdata=%h want %b %0d %h", c, mem_we,
                                  mem_addr, mem_wdata, we[g], addr[g*AW +: AW], wdata[g*DW +: DW]); end
         end
         checks++; if (rvalid !== exp_rv || (exp_rv != '0 && rdata !== exp_rd)) begin
            errors++; $display("FAIL rnd_read c%0d: rvalid=%b rdata=%h want %b %h", c, rvalid, rdata, exp_rv, exp_rd); end
         if (m_owner >= 0) begin
            if (!lock[m_owner]) begin m_ptr = (m_owner + 1) % N; m_owner = -1; end
         end else if (g >= 0) begin
            m_ptr = (g + 1) % N;
            if (lock[g]) m_owner = g;
         end
         exp_rv = '0;
         if (g >= 0) begin
            a = int'(addr[g*AW +: AW]);
            if (we[g]) shadow[a] = wdata[g*DW +: DW];
            else begin exp_rv = oh(g); exp_rd = shadow[a]; end
            pend[g] = 1'b0;
         end
         tick();
      end
      clear_all();
      tick();
   endtask

   initial begin
      errors = 0; checks = 0;
      pl_en = 1'b0; pl_addr = '0; pl_data = '0;
      rst = 1'b1;
      clear_all();
      @(negedge clk);
      test_reset();
      test_single_read();
      test_round_robin();
      test_lock();
      test_lock_idle();
      test_write_read();
      test_reset_mid_lock();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
